// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based debounce and a valid/ack event port.
// Press codes are {4'h0, key}, release codes {4'h8, key}; key = row_idx*4 + col_idx.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] KB,
    output logic       kb_valid,
    input  logic       kb_ack,
    output logic       overrun
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

    typedef enum logic {StReleased, StPressed} state_e;

    logic [DivW-1:0] div_q;
    logic [1:0]      col_idx_q;
    logic [15:0]     map_q;
    logic [15:0]     frame_map;
    logic            sample;
    logic            eval;

    state_e          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      held_q, held_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            emit_q, emit_d;
    logic [7:0]      emit_code_q, emit_code_d;

    logic [7:0]      kb_q;
    logic            valid_q;
    logic            ovr_q;

    logic [4:0]      n_ones;
    logic [3:0]      key_idx;
    logic            single;
    logic            has_held;

    assign sample = (div_q == DivW'(SCAN_DIV - 1));
    assign eval   = sample && (col_idx_q == 2'd3);
    assign col    = ~(4'b0001 << col_idx_q);

    // Current column's rows merged in, so the frame is complete on the column-3 sample.
    always_comb begin
        frame_map = map_q;
        for (int r = 0; r < 4; r++) begin
            frame_map[{2'(r), col_idx_q}] = ~row[r];
        end
    end

    always_comb begin
        n_ones  = '0;
        key_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_map[i]) begin
                n_ones  = n_ones + 5'd1;
                key_idx = 4'(i);
            end
        end
    end

    assign single   = (n_ones == 5'd1);
    assign has_held = frame_map[held_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
            map_q     <= '0;
        end else if (sample) begin
            div_q     <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            map_q     <= frame_map;
        end else begin
            div_q     <= div_q + DivW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        held_d      = held_q;
        cnt_d       = cnt_q;
        emit_d      = 1'b0;
        emit_code_d = emit_code_q;
        if (eval) begin
            unique case (state_q)
                StReleased: begin
                    if (single) begin
                        if (key_idx == cand_q) begin
                            cnt_d = cnt_q + CntW'(1);
                        end else begin
                            cand_d = key_idx;
                            cnt_d  = CntW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                    if (cnt_d == CntW'(DEBOUNCE)) begin
                        emit_d      = 1'b1;
                        emit_code_d = {4'h0, cand_d};
                        held_d      = cand_d;
                        cnt_d       = '0;
                        state_d     = StPressed;
                    end
                end
                StPressed: begin
                    if (has_held) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if (cnt_d == CntW'(DEBOUNCE)) begin
                        emit_d      = 1'b1;
                        emit_code_d = {4'h8, held_q};
                        cnt_d       = '0;
                        state_d     = StReleased;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StReleased;
            cand_q      <= '0;
            held_q      <= '0;
            cnt_q       <= '0;
            emit_q      <= 1'b0;
            emit_code_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            held_q      <= held_d;
            cnt_q       <= cnt_d;
            emit_q      <= emit_d;
            emit_code_q <= emit_code_d;
        end
    end

    // An ack frees the slot in the same cycle an event arrives, so the event is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kb_q    <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (emit_q) begin
            if (!valid_q || kb_ack) begin
                kb_q    <= emit_code_q;
                valid_q <= 1'b1;
                ovr_q   <= 1'b0;
            end else begin
                ovr_q   <= 1'b1;
            end
        end else if (kb_ack && valid_q) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign KB       = kb_q;
    assign kb_valid = valid_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key/ack traffic, checked each
// cycle against a frame-history model of the debounce rules and the consumer handshake.
module tb_keypad_scanner;

    localparam int D     = 3;
    localparam int SDIV  = 4;
    localparam int FRAME = 4 * SDIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] KB;
    logic       kb_valid;
    logic       kb_ack = 1'b0;
    logic       overrun;

    logic [15:0] keys = 16'h0000;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: frames seen since the last accepted transition, plus consumer-side state.
    logic [15:0] hist[$];
    bit          m_pressed;
    int          m_held;
    bit          pend;
    logic [7:0]  pend_code;
    logic [7:0]  e_kb;
    bit          e_valid;
    bit          e_ovr;

    keypad_scanner #(
        .SCAN_DIV (SDIV),
        .DEBOUNCE (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .KB       (KB),
        .kb_valid (kb_valid),
        .kb_ack   (kb_ack),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its (low-driven) column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && keys[4'(r * 4 + c)]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic int single_idx(input logic [15:0] m);
        if ($countones(m) != 1) return -1;
        for (int i = 0; i < 16; i++) begin
            if (m[4'(i)]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        cyc       = 0;
        hist.delete();
        m_pressed = 0;
        m_held    = 0;
        pend      = 0;
        pend_code = 8'h00;
        e_kb      = 8'h00;
        e_valid   = 0;
        e_ovr     = 0;
    endtask

    // Accept a transition when the last D frames since the previous one all agree.
    task automatic frame_eval(input logic [15:0] m);
        bit ok;
        int k;
        hist.push_back(m);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() < D) return;
        ok = 1;
        if (!m_pressed) begin
            k = single_idx(hist[0]);
            foreach (hist[i]) if (k < 0 || single_idx(hist[i]) != k) ok = 0;
            if (ok) begin
                pend      = 1;
                pend_code = {4'h0, 4'(k)};
                m_pressed = 1;
                m_held    = k;
                hist.delete();
            end
        end else begin
            foreach (hist[i]) if (hist[i][4'(m_held)]) ok = 0;
            if (ok) begin
                pend      = 1;
                pend_code = {4'h8, 4'(m_held)};
                m_pressed = 0;
                hist.delete();
            end
        end
    endtask

    task automatic step(input bit ack);
        logic [3:0] ec;
        kb_ack = ack;
        @(posedge clk);
        cyc++;
        if (pend) begin
            if (!e_valid || ack) begin
                e_kb    = pend_code;
                e_valid = 1;
                e_ovr   = 0;
            end else begin
                e_ovr   = 1;
            end
            pend = 0;
        end else if (ack && e_valid) begin
            e_valid = 0;
            e_ovr   = 0;
        end
        if (cyc % FRAME == 0) frame_eval(keys);
        #1;
        kb_ack = 1'b0;
        ec = ~(4'b0001 << ((cyc / SDIV) % 4));
        check("col", col, ec);
        check("kb", KB, e_kb);
        check("kb_valid", kb_valid, e_valid);
        check("overrun", overrun, e_ovr);
    endtask

    // One full frame with a fixed key set; ack_at (1..FRAME) forces an ack on that step.
    task automatic run_frame(input logic [15:0] k, input int ack_at, input int ack_pct);
        keys = k;
        for (int i = 1; i <= FRAME; i++) begin
            step((i == ack_at) || (int'($urandom_range(99)) < ack_pct));
        end
    endtask

    task automatic run_frames(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) run_frame(k, 0, 0);
    endtask

    initial begin
        logic [15:0] rk;
        int          sel;
        int          nfr;

        model_reset();
        #12;
        check("rst_col", col, 4'b1110);
        check("rst_kb", KB, 8'h00);
        check("rst_valid", kb_valid, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Key 6 press, ack, release, ack.
        run_frames(16'h0040, D);
        step(1'b0);
        check("press6_kb", KB, 8'h06);
        check("press6_valid", kb_valid, 1'b1);
        for (int i = 2; i <= FRAME; i++) step(i == 5);
        run_frames(16'h0000, D);
        step(1'b0);
        check("rel6_kb", KB, 8'h86);
        for (int i = 2; i <= FRAME; i++) step(i == 3);
        check("rel6_acked", kb_valid, 1'b0);

        // Bounce: key 6 in alternate frames never settles.
        for (int i = 0; i < 8; i++) run_frame((i % 2 == 0) ? 16'h0040 : 16'h0000, 0, 0);
        check("bounce_quiet", kb_valid, 1'b0);

        // Keys 1 and 5 together, then key 5 released.
        run_frames(16'h0022, 5);
        check("multi_quiet", kb_valid, 1'b0);
        run_frames(16'h0002, D);
        run_frame(16'h0002, 4, 0);
        run_frames(16'h0000, D);
        run_frame(16'h0000, 4, 0);

        // Overrun: key 3 unacked, its release and key 9 press are dropped.
        run_frames(16'h0008, D);
        run_frames(16'h0000, D);
        run_frames(16'h0200, D);
        check("ovr_kb_held", KB, 8'h03);
        check("ovr_set", overrun, 1'b1);
        run_frame(16'h0200, 5, 0);
        check("ovr_cleared", overrun, 1'b0);
        run_frames(16'h0000, D);
        run_frames(16'h0004, D);
        run_frame(16'h0004, 1, 0);
        check("ack_emit_kb", KB, 8'h02);
        check("ack_emit_valid", kb_valid, 1'b1);
        run_frame(16'h0004, 2, 0);
        run_frames(16'h0000, D);
        run_frame(16'h0000, 2, 0);

        // Random key sets held for random frame counts, random acks.
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(3));
            rk  = 16'h0000;
            if (sel == 1 || sel == 2) rk = 16'h0001 << $urandom_range(15);
            if (sel == 3) rk = (16'h0001 << $urandom_range(15)) | (16'h0001 << $urandom_range(15));
            nfr = int'($urandom_range(1, 5));
            for (int f = 0; f < nfr; f++) run_frame(rk, 0, 15);
        end
        run_frames(16'h0000, D + 1);
        run_frame(16'h0000, 3, 0);

        // Asynchronous reset mid-frame (column 2 driven) with an event pending.
        run_frames(16'h1000, D);
        for (int i = 0; i < 9; i++) step(1'b0);
        check("pre_rst_valid", kb_valid, 1'b1);
        check("pre_rst_col", col, 4'b1011);
        #2;
        rst = 1'b0;
        #1;
        check("arst_kb", KB, 8'h00);
        check("arst_valid", kb_valid, 1'b0);
        check("arst_ovr", overrun, 1'b0);
        check("arst_col", col, 4'b1110);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run_frames(16'h1000, D);
        step(1'b0);
        check("post_rst_kb", KB, 8'h0C);
        check("post_rst_valid", kb_valid, 1'b1);
        for (int i = 2; i <= FRAME; i++) step(i == 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the MCU KB input. Scans a 4x4 matrix keypad, debounces it, and presents press/release key codes on KB with a valid/ack handshake.
- The MCU core is the consumer: it reads KB while kb_valid is high and pulses kb_ack.
- Sits between the board keypad pins and the MCU_Toplevel KB port.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is driven; must be >= 2.
- DEBOUNCE, 4, consecutive identical frames required to accept a press or release; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- row  input  4  keypad rows, active-low (external pull-ups).
- col  output  4  keypad column drive, one-hot active-low.
- KB  output  8  key event code, held stable while kb_valid = 1.
- kb_valid  output  1  KB holds an unconsumed event.
- kb_ack  input  1  consumer acknowledge, single-cycle pulse.
- overrun  output  1  sticky flag: an event was dropped.

Behaviour:
- Reset (rst = 0, async) sets: col = 4'b1110; KB = 8'h00; kb_valid = 0; overrun = 0; column index 0; divider 0; debounce count 0; FSM = RELEASED.
- Scan:
  - col = ~(4'b0001 << col_idx).
  - Divider counts 0..SCAN_DIV-1. On the last count, row is sampled into a per-frame 16-bit map, then col_idx advances (3 wraps to 0).
  - A frame is 4*SCAN_DIV cycles. It is evaluated on the sample cycle of column 3.
  - Key index = row_idx*4 + col_idx, where row_idx is the position of the low row bit.
- Frame result: NONE (no bits), SINGLE(k) (exactly one bit), MULTI (two or more bits).
- FSM RELEASED:
  - SINGLE(k) with k equal to the candidate: count++. Any other SINGLE(k): candidate = k, count = 1.
  - NONE or MULTI: count = 0.
  - When count reaches DEBOUNCE: emit press code {4'h0, k}, held = k, count = 0, go to PRESSED.
- FSM PRESSED:
  - A frame without the held key (NONE, SINGLE of another key, or MULTI without held): count++.
  - A frame containing the held key: count = 0.
  - When count reaches DEBOUNCE: emit release code {4'h8, held}, count = 0, go to RELEASED.
  - A new key is not reported until the release has been emitted.
- Emit: an event is loaded into KB the cycle after the evaluating sample edge, and kb_valid = 1 on that same cycle.
  - Press latency from stable contact at a frame boundary is DEBOUNCE frames + 1 cycle.
- Handshake:
  - kb_ack while kb_valid = 1: kb_valid = 0 next cycle, and overrun is cleared next cycle.
  - kb_ack while kb_valid = 0: ignored.
  - KB is not modified on ack; it keeps its last value.
- Simultaneous events:
  - Emit and kb_ack in the same cycle: the new event is loaded, kb_valid stays 1, overrun = 0.
  - Emit while kb_valid = 1 and no ack: the event is dropped, KB is unchanged, and overrun = 1 until the next ack. The FSM still changes state.
- Reset mid-frame or with an event pending: all state returns to reset values immediately. The partial frame is discarded and scanning restarts at column 0.

Test Plan:
- SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles). Release rst. Hold key 6 (row1 low while col2 driven) from frame 0 -> col steps 1110, 1101, 1011, 0111 every 4 cycles; kb_valid rises 1 cycle after the frame-2 evaluation; KB = 8'h06; overrun = 0.
- Ack, then release key 6 for 3 frames -> KB = 8'h86 and kb_valid = 1 one cycle after the 3rd empty frame; ack -> kb_valid = 0 next cycle.
- Key 6 present in alternate frames for 8 frames (bounce) -> no event; kb_valid stays 0.
- Keys 1 and 5 held together for 5 frames (MULTI) -> no event. Then release key 5 -> press 8'h01 after 3 frames.
- Press key 3 and never ack; release; press key 9 -> KB stays 8'h03 and overrun = 1. Ack -> kb_valid = 0 and overrun = 0 next cycle. Ack on the same cycle as an emit -> new code loaded, kb_valid stays 1.
- With kb_valid = 1 and mid-frame at col 1011, assert rst = 0 asynchronously (between clock edges) -> KB = 00, kb_valid = 0, overrun = 0, col = 1110 immediately. After rst = 1, a held key is reported after 3 full frames.
